// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: shared types and constants for the register-file access controller.
`default_nettype none

package riscv_rf_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_DU_RD  = 2'd2,
    ST_DU_ACK = 2'd3
  } rf_state_e;

  // Number of registers swept by the clear sequence (x0 is hardwired and skipped).
  function automatic int unsigned rf_clear_len(input int unsigned ar_bits);
    return (32'd1 << ar_bits) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_rf_ctrl.sv
// riscv_rf_ctrl: arbitrates pipeline writeback and debug-unit access to the register file.
// Optional RF_CLEAR_EN macro adds a post-reset sweep that zeroes x1..xN.
`default_nettype none

module riscv_rf_ctrl
  import riscv_rf_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int AR_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we,
  input  logic [AR_BITS-1:0] wb_dst,
  input  logic [XLEN-1:0]    wb_dstv,
  input  logic               du_stall,
  input  logic               du_req,
  input  logic               du_we,
  input  logic [AR_BITS-1:0] du_addr,
  input  logic [XLEN-1:0]    du_wdata,
  output logic               du_ack,
  output logic [XLEN-1:0]    du_rdata,
  output logic               rf_we,
  output logic [AR_BITS-1:0] rf_dst,
  output logic [XLEN-1:0]    rf_dstv,
  output logic [AR_BITS-1:0] rf_src,
  input  logic [XLEN-1:0]    rf_srcv,
  output logic               busy
);

`ifdef RF_CLEAR_EN
  localparam rf_state_e          RST_STATE = ST_CLEAR;
  localparam logic [AR_BITS-1:0] CLR_LAST  = AR_BITS'(rf_clear_len(AR_BITS));
  logic [AR_BITS-1:0] clr_cnt_q;
  logic [AR_BITS-1:0] clr_cnt_d;
  assign clr_cnt_d = clr_cnt_q + 1'b1;
`else
  localparam rf_state_e RST_STATE = ST_IDLE;
`endif

  rf_state_e         state_q;
  logic              du_ack_q;
  logic [XLEN-1:0]   du_rdata_q;
  logic              dbg_grant;

  // Writeback always wins in IDLE; the debug request simply waits for a free cycle.
  assign dbg_grant = (state_q == ST_IDLE) && !wb_we && du_req && du_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      du_ack_q   <= 1'b0;
      du_rdata_q <= '0;
`ifdef RF_CLEAR_EN
      clr_cnt_q  <= AR_BITS'(1);
`endif
    end else begin
      du_ack_q <= 1'b0;
      case (state_q)
`ifdef RF_CLEAR_EN
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == CLR_LAST) state_q <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (dbg_grant) begin
            state_q  <= du_we ? ST_DU_ACK : ST_DU_RD;
            du_ack_q <= du_we;
          end
        end
        ST_DU_RD: begin
          du_rdata_q <= rf_srcv;
          du_ack_q   <= 1'b1;
          state_q    <= ST_DU_ACK;
        end
        ST_DU_ACK: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_dst  = wb_dst;
    rf_dstv = wb_dstv;
    rf_src  = du_addr;
    case (state_q)
`ifdef RF_CLEAR_EN
      ST_CLEAR: begin
        rf_we   = 1'b1;
        rf_dst  = clr_cnt_q;
        rf_dstv = '0;
        rf_src  = '0;
      end
`endif
      ST_IDLE: begin
        if (wb_we) begin
          rf_we = (wb_dst != '0);
        end else if (dbg_grant && du_we) begin
          rf_we   = (du_addr != '0);
          rf_dst  = du_addr;
          rf_dstv = du_wdata;
        end
      end
      default: ;
    endcase
  end

  assign du_ack   = du_ack_q;
  assign du_rdata = du_rdata_q;

`ifdef RF_CLEAR_EN
  assign busy = (state_q == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_rf_ctrl.sv
// tb_riscv_rf_ctrl: directed self-checking bench for riscv_rf_ctrl with a small register-file model.
`default_nettype none

module tb_riscv_rf_ctrl;

  localparam int XLEN    = 64;
  localparam int AR_BITS = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               wb_we;
  logic [AR_BITS-1:0] wb_dst;
  logic [XLEN-1:0]    wb_dstv;
  logic               du_stall, du_req, du_we;
  logic [AR_BITS-1:0] du_addr;
  logic [XLEN-1:0]    du_wdata;
  logic               du_ack;
  logic [XLEN-1:0]    du_rdata;
  logic               rf_we;
  logic [AR_BITS-1:0] rf_dst;
  logic [XLEN-1:0]    rf_dstv;
  logic [AR_BITS-1:0] rf_src;
  logic [XLEN-1:0]    rf_srcv;
  logic               busy;

  int total = 0;
  int bad   = 0;

`ifdef RF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  riscv_rf_ctrl #(.XLEN(XLEN), .AR_BITS(AR_BITS)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_dstv(wb_dstv),
    .du_stall(du_stall), .du_req(du_req), .du_we(du_we),
    .du_addr(du_addr), .du_wdata(du_wdata),
    .du_ack(du_ack), .du_rdata(du_rdata),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_dstv(rf_dstv),
    .rf_src(rf_src), .rf_srcv(rf_srcv), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous write, registered 1-cycle read.
  logic [XLEN-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_we) mem[rf_dst] <= rf_dstv;
    rf_srcv <= mem[rf_src];
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_we = 0; wb_dst = 0; wb_dstv = 0;
    du_stall = 0; du_req = 0; du_we = 0; du_addr = 5'd9; du_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_du_ack", {63'd0, du_ack}, 64'd0);
    chk("rst_du_rdata", du_rdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, {63'd0, CLR});
    chk("rst_rf_src", {59'd0, rf_src}, CLR ? 64'd0 : 64'd9);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clear();
    #1;
    if (CLR) begin
      for (int i = 1; i <= 31; i++) begin
        chk("clr_busy", {63'd0, busy}, 64'd1);
        chk("clr_we", {63'd0, rf_we}, 64'd1);
        chk("clr_dst", {59'd0, rf_dst}, 64'(i));
        chk("clr_dstv", rf_dstv, 64'd0);
        @(negedge clk); #1;
      end
    end
    chk("clr_done_busy", {63'd0, busy}, 64'd0);
    chk("clr_done_src", {59'd0, rf_src}, 64'd9);
  endtask

  task automatic test_wb_write();
    @(negedge clk);
    wb_we = 1; wb_dst = 5'd5; wb_dstv = 64'hA5; #1;
    chk("wb_we", {63'd0, rf_we}, 64'd1);
    chk("wb_dst", {59'd0, rf_dst}, 64'd5);
    chk("wb_dstv", rf_dstv, 64'hA5);
    wb_dst = 5'd0; #1;
    chk("wb_x0_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk);
    wb_dst = 5'd7; wb_dstv = 64'h1234; #1;
    chk("wb_x7_we", {63'd0, rf_we}, 64'd1);
    @(negedge clk);
    wb_we = 0;
  endtask

  task automatic test_du_read();
    @(negedge clk);
    du_stall = 1; du_req = 1; du_we = 0; du_addr = 5'd7; #1;
    chk("rd_grant_src", {59'd0, rf_src}, 64'd7);
    chk("rd_grant_we", {63'd0, rf_we}, 64'd0);
    chk("rd_grant_ack", {63'd0, du_ack}, 64'd0);
    @(negedge clk);
    wb_we = 1; wb_dst = 5'd9; wb_dstv = 64'h77; du_stall = 0; #1;
    chk("rd_durd_ack", {63'd0, du_ack}, 64'd0);
    chk("rd_durd_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk); #1;
    chk("rd_ack", {63'd0, du_ack}, 64'd1);
    chk("rd_data", du_rdata, 64'h1234);
    chk("rd_ack_we", {63'd0, rf_we}, 64'd0);
    wb_we = 0; du_req = 0;
    @(negedge clk); #1;
    chk("rd_ack_pulse", {63'd0, du_ack}, 64'd0);
    chk("rd_data_hold", du_rdata, 64'h1234);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wb_we = 1; wb_dst = 5'd2; wb_dstv = 64'h11;
    du_stall = 1; du_req = 1; du_we = 1; du_addr = 5'd3; du_wdata = 64'hBEEF; #1;
    chk("pri_c1_dst", {59'd0, rf_dst}, 64'd2);
    chk("pri_c1_dstv", rf_dstv, 64'h11);
    @(negedge clk);
    wb_dst = 5'd4; wb_dstv = 64'h22; #1;
    chk("pri_c2_dst", {59'd0, rf_dst}, 64'd4);
    chk("pri_c2_ack", {63'd0, du_ack}, 64'd0);
    @(negedge clk);
    wb_we = 0; #1;
    chk("pri_c3_we", {63'd0, rf_we}, 64'd1);
    chk("pri_c3_dst", {59'd0, rf_dst}, 64'd3);
    chk("pri_c3_dstv", rf_dstv, 64'hBEEF);
    chk("pri_c3_ack", {63'd0, du_ack}, 64'd0);
    @(negedge clk); #1;
    chk("pri_ack", {63'd0, du_ack}, 64'd1);
    chk("pri_ack_we", {63'd0, rf_we}, 64'd0);
    du_req = 0;
    @(negedge clk); #1;
    chk("pri_ack_pulse", {63'd0, du_ack}, 64'd0);
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    du_stall = 1; du_req = 1; du_we = 1; du_addr = 5'd0; du_wdata = 64'hFF; #1;
    chk("x0_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk); #1;
    chk("x0_ack", {63'd0, du_ack}, 64'd1);
    du_req = 0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    du_stall = 1; du_req = 1; du_we = 0; du_addr = 5'd7;
    @(negedge clk);
    #1; rst = 1; du_req = 0;
    #2;
    chk("rstmid_rdata", du_rdata, 64'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rstmid_ack", {63'd0, du_ack}, 64'd0);
    end
    chk("rstmid_busy", {63'd0, busy}, {63'd0, CLR});
    chk("rstmid_src", {59'd0, rf_src}, CLR ? 64'd0 : 64'd7);
    chk("rstmid_rdata_hold", du_rdata, 64'd0);
  endtask

  initial begin
    test_reset();
    test_clear();
    test_wb_write();
    test_du_read();
    test_back_to_back();
    test_x0_write();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_rf_ctrl.md
RISCV_RF_CTRL -- requirements
Module: riscv_rf_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, register width.
REQ-002 SHALL have parameter AR_BITS, default 5, register address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports wb_we / wb_dst / wb_dstv, input, 1 / AR_BITS / XLEN, pipeline writeback request.
REQ-006 SHALL have ports du_stall / du_req / du_we, input, 1 each, debug halted / access request / 1=write 0=read.
REQ-007 SHALL have ports du_addr / du_wdata, input, AR_BITS / XLEN, debug register address and write data.
REQ-008 SHALL have ports du_ack / du_rdata, output, 1 / XLEN, debug completion pulse and read data.
REQ-009 SHALL have ports rf_we / rf_dst / rf_dstv, output, 1 / AR_BITS / XLEN, register file write port.
REQ-010 SHALL have ports rf_src / rf_srcv, output / input, AR_BITS / XLEN, debug read address and registered read data with 1-cycle latency.
REQ-011 SHALL have port busy, output, 1, high while clear sweep runs; pipeline stalls on it.

Function
REQ-012 SHALL implement FSM states CLEAR, IDLE, DU_RD, DU_ACK.
REQ-013 IDLE: wb_we=1 and wb_dst!=0 SHALL drive rf_we=1, rf_dst=wb_dst, rf_dstv=wb_dstv in the same cycle (combinational).
REQ-014 IDLE: a debug request SHALL be granted only when du_req=1, du_stall=1 and wb_we=0; wb_we has priority and the request waits.
REQ-015 Granted debug write: rf_we=1 (unless du_addr=0), rf_dst=du_addr, rf_dstv=du_wdata that cycle; next state DU_ACK.
REQ-016 Granted debug read: rf_src=du_addr that cycle; next state DU_RD.
REQ-017 DU_RD: du_rdata SHALL capture rf_srcv; next state DU_ACK; wb_we is ignored in DU_RD.
REQ-018 DU_ACK: du_ack=1 for exactly one cycle; next state IDLE; du_rdata holds until the next read capture.
REQ-019 Writes to address 0 from either source SHALL never assert rf_we; a debug write to x0 is still acknowledged.
REQ-020 Requester SHALL hold du_req and operands until du_ack; du_req sampled only in IDLE, so a read completes in 3 cycles and a write in 2.
REQ-021 du_stall falling in DU_RD or DU_ACK SHALL NOT abort the access.
REQ-022 rf_src SHALL equal du_addr in all states except CLEAR, where it is 0.
REQ-023 rf_we SHALL be 0 in DU_RD and DU_ACK.

Reset
REQ-024 On rst: du_ack=0, du_rdata=0, clear counter=1, state=CLEAR when RF_CLEAR_EN is defined, else IDLE.
REQ-025 rst asserted mid-access SHALL drop the access silently; no du_ack follows.

Configuration
REQ-026 Macro RF_CLEAR_EN defined: CLEAR writes zero to registers 1..2^AR_BITS-1, one per cycle ascending, busy=1, then IDLE; wb_we and du_req ignored during CLEAR.
REQ-027 RF_CLEAR_EN undefined: no CLEAR state or counter logic; busy tied 0.

Structure
REQ-028 Shared package riscv_rf_pkg SHALL hold the FSM state enum and the clear-sweep length constant.
REQ-029 No sub-module; the clear counter is local to the block.

Verification
REQ-030 RF_CLEAR_EN, release rst -> busy=1 for 31 cycles, rf_we=1 with rf_dst 1..31, rf_dstv=0, then busy=0.
REQ-031 IDLE, wb_we=1, wb_dst=5, wb_dstv=0xA5 -> same-cycle rf_we=1, rf_dst=5, rf_dstv=0xA5; wb_dst=0 -> rf_we=0.
REQ-032 du_stall=1, du_req=1, du_we=0, du_addr=7, rf_srcv=0x1234 -> rf_src=7, du_rdata=0x1234, du_ack=1 two cycles after grant.
REQ-033 du_req=1, du_we=1, du_addr=3, du_wdata=0xBEEF while wb_we=1 for 2 cycles -> wb writes first, debug write on 3rd cycle, du_ack next cycle.
REQ-034 Debug read granted, rst pulsed in DU_RD -> du_ack never asserts, du_rdata=0, state CLEAR/IDLE per macro.
